// File: rtl/cocofdc_host_master.sv
// cocofdc_host_master: valid/ready initiator for the FDC CPLD host port.
// Generates timed a_sel strobe cycles, including the two-strobe pipelined read.
module cocofdc_host_master #(
    parameter int SETUP  = 2,
    parameter int STROBE = 4,
    parameter int HOLD   = 16,
    parameter int CW     = 5
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rw,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] a_addrbus,
    output logic        a_rw,
    output logic        a_sel,
    output logic [7:0]  a_data_o,
    output logic        a_data_oe,
    input  logic [7:0]  a_data_i,
    input  logic        dirty,
    output logic        dirty_irq
);
    typedef enum logic [2:0] {
        S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_FSETUP, S_FSTROBE, S_DONE
    } state_t;

    // Counter reload values; a zero-length phase still lasts one cycle.
    localparam logic [CW-1:0] SETUP_L  = CW'((SETUP  > 1) ? SETUP  - 1 : 0);
    localparam logic [CW-1:0] STROBE_L = CW'((STROBE > 1) ? STROBE - 1 : 0);
    localparam logic [CW-1:0] HOLD_L   = CW'((HOLD   > 1) ? HOLD   - 1 : 0);

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic          pass_q;
    logic          req_ready_q;
    logic          rsp_valid_q;
    logic [7:0]    rsp_rdata_q;
    logic [15:0]   addr_q;
    logic          a_rw_q;
    logic          a_sel_q;
    logic [7:0]    wdata_q;
    logic [2:0]    dsync_q;
    logic          dirty_irq_q;

    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pass_q      <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
            addr_q      <= 16'h0000;
            a_rw_q      <= 1'b1;
            a_sel_q     <= 1'b0;
            wdata_q     <= 8'h00;
        end else begin
            rsp_valid_q <= 1'b0;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req_valid) begin
                            addr_q      <= req_addr;
                            a_rw_q      <= req_rw;
                            wdata_q     <= req_wdata;
                            req_ready_q <= 1'b0;
                            state_q     <= S_SETUP;
                            cnt_q       <= SETUP_L;
                        end
                    end
                    S_SETUP, S_FSETUP: begin
                        state_q <= (state_q == S_SETUP) ? S_STROBE : S_FSTROBE;
                        cnt_q   <= STROBE_L;
                        a_sel_q <= 1'b1;
                    end
                    S_STROBE, S_FSTROBE: begin
                        if (state_q == S_FSTROBE) begin
                            rsp_rdata_q <= a_data_i;
                            pass_q      <= 1'b1;
                        end
                        state_q <= S_HOLD;
                        cnt_q   <= HOLD_L;
                        a_sel_q <= 1'b0;
                    end
                    S_HOLD: begin
                        if (!a_rw_q || pass_q) begin
                            state_q     <= S_DONE;
                            rsp_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_FSETUP;
                            cnt_q   <= SETUP_L;
                        end
                    end
                    S_DONE: begin
                        state_q     <= S_IDLE;
                        req_ready_q <= 1'b1;
                        pass_q      <= 1'b0;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // dsync_q[1] is the synchronised level, dsync_q[2] its previous value.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            dsync_q     <= 3'b000;
            dirty_irq_q <= 1'b0;
        end else begin
            dsync_q     <= {dsync_q[1:0], dirty};
            dirty_irq_q <= dsync_q[1] & ~dsync_q[2];
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign a_addrbus = addr_q;
    assign a_rw      = a_rw_q;
    assign a_sel     = a_sel_q;
    assign a_data_o  = wdata_q;
    assign a_data_oe = ~a_rw_q;
    assign dirty_irq = dirty_irq_q;
endmodule

// File: tb/tb_cocofdc_host_master.sv
// tb_cocofdc_host_master: directed plus randomised checks against a host-port responder
// and a written-value scoreboard.
module tb_cocofdc_host_master;
    localparam int S = 2, ST = 4, H = 16;

    logic        clock_50 = 1'b0, reset = 1'b0;
    logic        req_valid = 1'b0, req_rw = 1'b0, dirty = 1'b0;
    logic [15:0] req_addr = 16'h0000;
    logic [7:0]  req_wdata = 8'h00;
    logic        req_ready, rsp_valid, a_rw, a_sel, a_data_oe, dirty_irq;
    logic [7:0]  rsp_rdata, a_data_o, a_data_i;
    logic [15:0] a_addrbus;

    logic        f_req_valid = 1'b0, f_req_ready, f_rsp_valid, f_a_rw, f_a_sel, f_a_data_oe, f_dirty_irq;
    logic [7:0]  f_rsp_rdata, f_a_data_o;
    logic [15:0] f_a_addrbus;

    int tests = 0, fails = 0;

    always #5 clock_50 = ~clock_50;

    cocofdc_host_master dut (
        .clock_50(clock_50), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .a_addrbus(a_addrbus), .a_rw(a_rw), .a_sel(a_sel),
        .a_data_o(a_data_o), .a_data_oe(a_data_oe), .a_data_i(a_data_i), .dirty(dirty),
        .dirty_irq(dirty_irq)
    );

    cocofdc_host_master #(.STROBE(1), .HOLD(1)) u_fast (
        .clock_50(clock_50), .reset(reset), .req_valid(f_req_valid), .req_ready(f_req_ready),
        .req_rw(1'b0), .req_addr(16'h1234), .req_wdata(8'h55), .rsp_valid(f_rsp_valid),
        .rsp_rdata(f_rsp_rdata), .a_addrbus(f_a_addrbus), .a_rw(f_a_rw), .a_sel(f_a_sel),
        .a_data_o(f_a_data_o), .a_data_oe(f_a_data_oe), .a_data_i(8'h00), .dirty(1'b0),
        .dirty_irq(f_dirty_irq)
    );

    // Responder: writes commit and reads load the buffer when a strobe falls;
    // the buffer is presented only while a strobe is high.
    logic [7:0] mem [logic [15:0]];
    logic [7:0] ref_mem [logic [15:0]];
    logic [7:0] rbuf = 8'h00;

    function automatic logic [7:0] init_val(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hDA;
    endfunction

    function automatic logic [7:0] bus_rd(input logic [15:0] a);
        return mem.exists(a) ? mem[a] : init_val(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [15:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    always @(negedge a_sel) begin
        if (a_rw === 1'b0) mem[a_addrbus] = a_data_o;
        else rbuf = bus_rd(a_addrbus);
    end

    assign a_data_i = a_sel ? rbuf : 8'hEE;

    // Strobe width, inter-strobe gap and data-enable monitor.
    int hi = 0, lo = 0, min_gap = 1000, bad_w = 0, bad_oe = 0;
    bit seen = 0;
    always @(negedge clock_50) begin
        if (a_data_oe !== ~a_rw) bad_oe++;
        if (!reset) begin
            hi = 0; lo = 0; seen = 0;
        end else if (a_sel) begin
            if (hi == 0 && seen && lo < min_gap) min_gap = lo;
            hi++; lo = 0;
        end else begin
            if (hi != 0) begin
                if (hi != ST) bad_w++;
                seen = 1;
            end
            hi = 0; lo++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_txn(input bit rw, input logic [15:0] addr, input logic [7:0] wd, input bit chain);
        int lat, str, waited, bad;
        bit prev;
        logic [7:0] exp;
        exp = ref_rd(addr);
        @(negedge clock_50);
        req_valid = 1'b1; req_rw = rw; req_addr = addr; req_wdata = wd;
        waited = 0;
        while (!req_ready && waited < 100) begin
            @(negedge clock_50);
            waited++;
        end
        if (chain || waited >= 100) check("accept_wait", 32'(waited), 32'(0));
        lat = 0; str = 0; bad = 0; prev = 0;
        while (lat < 200) begin
            @(negedge clock_50);
            lat++;
            req_valid = chain; req_rw = 1'($urandom); req_addr = 16'($urandom); req_wdata = 8'($urandom);
            if (a_sel && !prev) str++;
            prev = a_sel;
            if (a_addrbus !== addr || a_rw !== rw || (!rw && a_data_o !== wd) || req_ready !== 1'b0) bad++;
            if (rsp_valid === 1'b1) break;
        end
        check(rw ? "rd_latency" : "wr_latency", 32'(lat), rw ? 32'(2 * (S + ST + H) + 1) : 32'(S + ST + H + 1));
        check("strobe_count", 32'(str), rw ? 32'(2) : 32'(1));
        check("bus_stable", 32'(bad), 32'(0));
        if (rw) check("rdata", 32'(rsp_rdata), 32'(exp));
        else ref_mem[addr] = wd;
    endtask

    task automatic dirty_rise(input int hold_cyc, input int window);
        int first, pulses;
        first = 0; pulses = 0;
        @(negedge clock_50);
        #3 dirty = 1'b1;
        for (int i = 1; i <= window; i++) begin
            @(negedge clock_50);
            if (i == hold_cyc) dirty = 1'b0;
            if (dirty_irq) begin
                pulses++;
                if (first == 0) first = i;
            end
        end
        check("dirty_latency", 32'(first >= 2 && first <= 3), 32'(1));
        check("dirty_pulses", 32'(pulses), 32'(1));
    endtask

    initial begin
        int n, lat, sel_hi, sel_rise, ok;
        bit prev;
        repeat (3) @(negedge clock_50);
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check("rst_addr", 32'(a_addrbus), 32'(0));
        check("rst_rw", 32'(a_rw), 32'(1));
        check("rst_sel", 32'(a_sel), 32'(0));
        check("rst_data_o", 32'(a_data_o), 32'(0));
        check("rst_oe", 32'(a_data_oe), 32'(0));
        check("rst_irq", 32'(dirty_irq), 32'(0));
        reset = 1'b1;

        do_txn(1'b0, 16'h0100, 8'h02, 1'b0);
        do_txn(1'b1, 16'h8000, 8'h00, 1'b0);
        do_txn(1'b0, 16'h0011, 8'h84, 1'b1);
        do_txn(1'b1, 16'h0011, 8'h00, 1'b0);
        for (int i = 0; i < 12; i++)
            do_txn(1'($urandom), 16'h0040 + 16'($urandom_range(0, 3)), 8'($urandom), 1'b0);

        // Reset during the first strobe of a read.
        @(negedge clock_50);
        req_valid = 1'b1; req_rw = 1'b1; req_addr = 16'h0042;
        @(negedge clock_50);
        req_valid = 1'b0;
        n = 0;
        while (!a_sel && n < 20) begin
            @(negedge clock_50);
            n++;
        end
        check("rst_mid_sel_seen", 32'(a_sel), 32'(1));
        @(posedge clock_50);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_sel", 32'(a_sel), 32'(0));
        check("rst_mid_oe", 32'(a_data_oe), 32'(0));
        check("rst_mid_ready", 32'(req_ready), 32'(1));
        repeat (2) @(negedge clock_50);
        reset = 1'b1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock_50);
            if (rsp_valid) n++;
        end
        check("rst_mid_no_rsp", 32'(n), 32'(0));
        do_txn(1'b1, 16'h0100, 8'h00, 1'b0);
        do_txn(1'b0, 16'h0042, 8'hC3, 1'b0);
        do_txn(1'b1, 16'h0042, 8'h00, 1'b0);

        check("strobe_width_errors", 32'(bad_w), 32'(0));
        check("strobe_gap_ok", 32'(min_gap >= H), 32'(1));
        check("oe_follows_rw", 32'(bad_oe), 32'(0));

        dirty_rise(3, 8);
        dirty_rise(0, 8);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock_50);
            if (dirty_irq) n++;
        end
        check("dirty_held_no_pulse", 32'(n), 32'(0));
        dirty = 1'b0;
        repeat (5) @(negedge clock_50);
        dirty_rise(0, 8);

        // Short-parameter instance: one-cycle strobe, five-cycle write.
        @(negedge clock_50);
        f_req_valid = 1'b1;
        lat = 0; sel_hi = 0; sel_rise = 0; prev = 0; ok = 0;
        while (lat < 50) begin
            @(negedge clock_50);
            lat++;
            f_req_valid = 1'b0;
            if (f_a_sel) sel_hi++;
            if (f_a_sel && !prev) sel_rise++;
            prev = f_a_sel;
            if (f_rsp_valid) begin
                ok = 1;
                break;
            end
        end
        check("fast_rsp_seen", 32'(ok), 32'(1));
        check("fast_latency", 32'(lat), 32'(5));
        check("fast_sel_cycles", 32'(sel_hi), 32'(1));
        check("fast_sel_pulses", 32'(sel_rise), 32'(1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cocofdc_host_master.md
Name: cocofdc_host_master

Overview:
- Host-side (AVR/FPGA-fabric) initiator for the FDC CPLD's parallel host port (a_addrbus/a_databus/a_rw/a_sel).
- Converts single-beat read/write requests on a valid/ready interface into correctly timed a_sel strobe cycles.
- Handles the port's pipelined read: the responder loads its read buffer after a strobe falls and presents it only during the next strobe.
- Also synchronises the CPLD "dirty" flag and raises a one-cycle notification on each rising edge.

Parameters:
- SETUP, 2, clock_50 cycles address/rw/data are stable before a_sel rises
- STROBE, 4, clock_50 cycles a_sel is held high
- HOLD, 16, clock_50 cycles address/rw/data are held after a_sel falls; covers responder sync, arbitration and SRAM access
- CW, 5, width of the internal timing counter; must hold max(SETUP, STROBE, HOLD)

Ports:
- clock_50  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  master idle and able to accept a request
- req_rw  in  1  1 = read, 0 = write
- req_addr  in  16  host-port address
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse: request complete
- rsp_rdata  out  8  read data; valid while rsp_valid is high, held until the next read completes
- a_addrbus  out  16  host-port address
- a_rw  out  1  host-port direction
- a_sel  out  1  host-port strobe, active high
- a_data_o  out  8  host-port data out
- a_data_oe  out  1  enable for a_data_o at the pad
- a_data_i  in  8  host-port data in
- dirty  in  1  CPLD dirty flag, asynchronous to clock_50
- dirty_irq  out  1  one-cycle pulse on each synchronised rising edge of dirty

Behaviour:
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, a_addrbus=0, a_rw=1, a_sel=0, a_data_o=0, a_data_oe=0, dirty_irq=0. State=IDLE, counter=0.
- A reset asserted mid-cycle drops a_sel and a_data_oe immediately. The request in flight is lost and no rsp_valid is generated.
- Handshake: a request is accepted on a clock edge where req_valid and req_ready are both high. req_ready goes low on the next cycle and stays low until the cycle after rsp_valid.
- On acceptance, latch addr, rw and wdata. a_addrbus and a_rw are driven from the latch for the whole transaction.
- a_data_oe = ~a_rw at all times. The master never drives the data bus while a_rw=1, so there is no contention with the responder.
- State machine (counter loads at each state entry and counts down to 0):
  - IDLE: wait for an accepted request, then go to SETUP.
  - SETUP: SETUP cycles, a_sel=0. Go to STROBE.
  - STROBE: STROBE cycles, a_sel=1. Go to HOLD.
  - HOLD: HOLD cycles, a_sel=0.
    - If write: go to DONE.
    - If read, first pass: go to FSETUP.
    - If read, second pass: go to DONE.
  - FSETUP: SETUP cycles, a_sel=0, same address. Go to FSTROBE.
  - FSTROBE: STROBE cycles, a_sel=1. On its last cycle, capture a_data_i into rsp_rdata. Go to HOLD (second pass).
  - DONE: one cycle, rsp_valid=1. Return to IDLE.
- Read totals 2 strobes. The fetch strobe's falling edge causes a harmless re-read.
- Write latency, acceptance to rsp_valid: SETUP+STROBE+HOLD+1 cycles (23 at default).
- Read latency, acceptance to rsp_valid: 2*(SETUP+STROBE+HOLD)+1 cycles (45 at default).
- Back-to-back requests: a new request is accepted the cycle after DONE. The HOLD period guarantees a gap of at least HOLD cycles between strobes.
- A parameter value of 0 is treated as 1; each phase is at least one cycle.
- dirty is synchronised through 2 flops. dirty_irq is high for one cycle when the synchronised value goes 0->1.
  - A level held high produces no further pulses.
  - Each new 0->1 transition produces a fresh pulse, independent of the master state.
- req_valid is ignored while req_ready=0. Changes to req_* after acceptance do not affect the cycle in progress.

Test Plan:
- Write: req addr=0x0100, wdata=0x02 -> one a_sel pulse of 4 cycles, a_rw=0, a_data_oe=1, a_data_o=0x02, address stable from SETUP through HOLD, rsp_valid 23 cycles after acceptance.
- Read: req addr=0x8000, responder model returns 0x5A on the second strobe -> exactly 2 a_sel pulses, a_data_oe=0 throughout, rsp_rdata=0x5A, rsp_valid at cycle 45.
- Back-to-back: write 0x0011/0x84 then read 0x0011 with req_valid held high -> second request accepted the cycle after first rsp_valid, at least 16 idle cycles between strobes, read returns 0x84.
- Reset mid-STROBE: assert reset during a read -> a_sel=0, a_data_oe=0, req_ready=1 immediately, no rsp_valid; next request completes normally.
- dirty: pulse dirty high for 3 cycles, hold it high, then toggle 0->1 -> dirty_irq single pulses 2-3 cycles after each rising edge, none while held.
- Parameters STROBE=1, HOLD=1: write -> a_sel high for exactly 1 cycle, rsp_valid at cycle 5.
